// File: rtl/rf_access_arbiter.sv
// Register-file port owner: zero-fills the file after reset, then round-robin arbitrates
// read and write requesters with same-cycle write-to-read forwarding on the response.
module rf_access_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NRD        = 2,
  parameter int unsigned NWR        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NRD-1:0]            rd_req,
  input  logic [NRD*ADDR_WIDTH-1:0] rd_addr1,
  input  logic [NRD*ADDR_WIDTH-1:0] rd_addr2,
  output logic [NRD-1:0]            rd_gnt,
  output logic                      rsp_valid,
  output logic [2:0]                rsp_id,
  output logic [WIDTH-1:0]          rsp_data1,
  output logic [WIDTH-1:0]          rsp_data2,
  input  logic [NWR-1:0]            wr_req,
  input  logic [NWR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NWR*WIDTH-1:0]      wr_data,
  output logic [NWR-1:0]            wr_gnt,
  output logic                      init_done,
  output logic [ADDR_WIDTH-1:0]     rf_addr_rd1,
  output logic [ADDR_WIDTH-1:0]     rf_addr_rd2,
  output logic [ADDR_WIDTH-1:0]     rf_addr_wr,
  output logic                      rf_wr_enable,
  output logic [WIDTH-1:0]          rf_wr,
  input  logic [WIDTH-1:0]          rf_rd1,
  input  logic [WIDTH-1:0]          rf_rd2
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic [2:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [2:0]              rsp_id_q, rsp_id_d;
  logic                    fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [WIDTH-1:0]        fwd_data_q, fwd_data_d;

  logic [7:0]              rd_req_ext, wr_req_ext;
  logic                    rd_any, wr_any, rd_win, wr_win;
  logic [2:0]              rd_idx, wr_idx, rd_sel, wr_sel;
  logic [ADDR_WIDTH-1:0]   rd_a1, rd_a2, wr_a;
  logic [WIDTH-1:0]        wr_d;

  assign rd_req_ext = 8'(rd_req);
  assign wr_req_ext = 8'(wr_req);

  // Scan upward from pointer+1 so the last winner has lowest priority.
  always_comb begin
    rd_any = 1'b0;
    rd_idx = '0;
    rd_sel = '0;
    for (int unsigned k = 1; k <= NRD; k++) begin
      rd_sel = 3'((32'(rd_ptr_q) + k) % NRD);
      if (!rd_any && rd_req_ext[rd_sel]) begin
        rd_any = 1'b1;
        rd_idx = rd_sel;
      end
    end
  end

  always_comb begin
    wr_any = 1'b0;
    wr_idx = '0;
    wr_sel = '0;
    for (int unsigned k = 1; k <= NWR; k++) begin
      wr_sel = 3'((32'(wr_ptr_q) + k) % NWR);
      if (!wr_any && wr_req_ext[wr_sel]) begin
        wr_any = 1'b1;
        wr_idx = wr_sel;
      end
    end
  end

  assign rd_win = (state_q == StRun) && rd_any;
  assign wr_win = (state_q == StRun) && wr_any;
  assign rd_gnt = rd_win ? (NRD'(1'b1) << rd_idx) : '0;
  assign wr_gnt = wr_win ? (NWR'(1'b1) << wr_idx) : '0;

  assign rd_a1 = rd_addr1[32'(rd_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign rd_a2 = rd_addr2[32'(rd_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_a  = wr_addr[32'(wr_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign wr_d  = wr_data[32'(wr_idx) * WIDTH +: WIDTH];

  // Reset gates the port controls directly so nothing is written while reset is held.
  always_comb begin
    rf_wr_enable = 1'b0;
    rf_addr_wr   = '0;
    rf_wr        = '0;
    rf_addr_rd1  = '0;
    rf_addr_rd2  = '0;
    if (!reset) begin
      if (state_q == StInit) begin
        rf_wr_enable = 1'b1;
        rf_addr_wr   = cnt_q;
      end else begin
        if (rd_win) begin
          rf_addr_rd1 = rd_a1;
          rf_addr_rd2 = rd_a2;
        end
        if (wr_win) begin
          rf_wr_enable = 1'b1;
          rf_addr_wr   = wr_a;
          rf_wr        = wr_d;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    rd_ptr_d    = rd_win ? rd_idx : rd_ptr_q;
    wr_ptr_d    = wr_win ? wr_idx : wr_ptr_q;
    rsp_valid_d = rd_win;
    rsp_id_d    = rd_win ? rd_idx : rsp_id_q;
    fwd1_d      = rd_win && wr_win && (wr_a == rd_a1);
    fwd2_d      = rd_win && wr_win && (wr_a == rd_a2);
    fwd_data_d  = wr_win ? wr_d : fwd_data_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d     = StRun;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rd_ptr_q    <= 3'(NRD - 1);
      wr_ptr_q    <= 3'(NWR - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      fwd1_q      <= 1'b0;
      fwd2_q      <= 1'b0;
      fwd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data1 = fwd1_q ? fwd_data_q : rf_rd1;
  assign rsp_data2 = fwd2_q ? fwd_data_q : rf_rd2;

endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Controller that owns the register-file ports (2 registered read ports, 1 write port; read data returned 1 cycle after address) and shares them between NRD read requesters and NWR write requesters.
- After reset it zero-fills the register file, because the register file itself has no content reset.
- In run mode it does independent round-robin arbitration for reads and writes.
- It forwards same-cycle write data onto the read response, so every response reflects all writes granted up to and including its grant cycle.

Parameters:
WIDTH, 32, data word width
ADDR_WIDTH, 9, register address width; SIZE = 2**ADDR_WIDTH
NRD, 2, number of read requesters (1..8)
NWR, 2, number of write requesters (1..8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
rd_req  input  NRD  read request per requester, held until granted
rd_addr1  input  NRD*ADDR_WIDTH  operand-1 address; requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_addr2  input  NRD*ADDR_WIDTH  operand-2 address, same packing
rd_gnt  output  NRD  one-hot read grant, combinational, same cycle as request
rsp_valid  output  1  read response valid
rsp_id  output  3  index of the requester that owns the response
rsp_data1  output  WIDTH  operand-1 data
rsp_data2  output  WIDTH  operand-2 data
wr_req  input  NWR  write request per requester, held until granted
wr_addr  input  NWR*ADDR_WIDTH  write address, packed as above
wr_data  input  NWR*WIDTH  write data, packed per requester
wr_gnt  output  NWR  one-hot write grant, combinational
init_done  output  1  high once zero-fill is complete
rf_addr_rd1  output  ADDR_WIDTH  to register file read port 1
rf_addr_rd2  output  ADDR_WIDTH  to register file read port 2
rf_addr_wr  output  ADDR_WIDTH  to register file write address
rf_wr_enable  output  1  to register file write enable
rf_wr  output  WIDTH  to register file write data
rf_rd1  input  WIDTH  from register file, valid 1 cycle after rf_addr_rd1
rf_rd2  input  WIDTH  from register file, valid 1 cycle after rf_addr_rd2

Behaviour:
- Reset (async, active-high):
  - state=INIT, init counter=0, init_done=0, rsp_valid=0, rsp_id=0, forwarding flags=0.
  - Read and write round-robin pointers reset to NRD-1 and NWR-1, so requester 0 has top priority first.
- Register-file control outputs while reset is asserted:
  - rf_wr_enable=0.
  - rf_addr_rd1, rf_addr_rd2, rf_addr_wr, rf_wr all drive 0.
- FSM state INIT:
  - rf_wr_enable=1, rf_addr_wr=counter, rf_wr=0.
  - counter increments each cycle.
  - All rd_gnt and wr_gnt are 0, whatever the requests.
  - When counter==SIZE-1, the next state is RUN and init_done goes 1 at that edge.
  - Total: exactly SIZE write cycles.
- FSM state RUN: never leaves except on reset. Reset mid-INIT or mid-RUN restarts zero-fill from address 0.
- Read arbitration (RUN):
  - Winner = first requester with rd_req=1, scanning upward from pointer+1 modulo NRD.
  - rd_gnt is one-hot for the winner; all zero if there are no requests.
  - The pointer updates to the winner only on a grant cycle.
- Read address muxing:
  - rf_addr_rd1/rf_addr_rd2 = winner's rd_addr1/rd_addr2.
  - With no winner they hold 0; the register file read is harmless.
- Read response timing:
  - rsp_valid=1 in cycle T+1 for a grant in cycle T, with rsp_id=winner.
  - rsp_data1=rf_rd1 and rsp_data2=rf_rd2, unless forwarding applies.
  - A single-cycle pulse per grant. Back-to-back grants give back-to-back responses; throughput is 1 per cycle.
- Write arbitration (RUN):
  - Same round-robin scheme with its own pointer.
  - rf_wr_enable=1, rf_addr_wr and rf_wr from the winner; rf_wr_enable=0 if there is no winner.
  - Write grants are independent of read grants; both may occur in the same cycle.
- Forwarding:
  - A read granted in cycle T plus a write granted in cycle T with rf_addr_wr==rf_addr_rd1 sets a registered flag for cycle T+1.
  - With the flag set, rsp_data1 = the registered write data from cycle T instead of rf_rd1.
  - rd2 is handled the same way, independently.
  - If both operands match, both are forwarded.
- Writes granted before cycle T need no forwarding; the register file already holds them.
- Grants are combinational from rd_req/wr_req and registered state. There are no combinational paths from rf_rd1/rf_rd2 to any grant.
- rsp_id width is fixed at 3; unused upper bits are 0.

Test Plan:
- ADDR_WIDTH=3: release reset → rf_wr_enable=1 for exactly 8 cycles, addresses 0..7, data 0; init_done rises after the 8th; a read of addr 5 then returns 0.
- Requests during INIT: rd_req=2'b11 and wr_req=2'b01 held from reset → no grants until init_done=1; first read grant goes to requester 0, and the next cycle to requester 1.
- Write round-robin: both writers request continuously (W0: addr 3/0xAAAA, W1: addr 4/0x5555) → grants alternate W0,W1,W0; a later read of 3 and 4 gives 0xAAAA and 0x5555.
- Forwarding: same cycle, W0 writes 0x1234 to addr 6 and R1 reads addr1=6, addr2=2 → next cycle rsp_id=1, rsp_data1=0x1234, rsp_data2=old value of addr 2.
- Back-to-back reads: R0 held 4 cycles → 4 consecutive rsp_valid pulses, each with rsp_id=0.
- Async reset mid-RUN: assert reset between edges → rsp_valid and rf_wr_enable drop immediately, init_done=0; after release, zero-fill restarts at addr 0.
